// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result bus of the ALU command sequencer.
// The sequencer attaches through the slave modport. The master modport is the
// view of whoever supplies commands, evaluates the ALU and consumes results.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 3,
  parameter int SEL_W  = 2,
  parameter int RES_W  = 6
);
  // Packed command: [DATA_W-1:0]=A, [2*DATA_W-1:DATA_W]=B, top SEL_W bits=sel
  logic [2*DATA_W+SEL_W-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  // Registered operands to the external combinational ALU and its result
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [SEL_W-1:0]          alu_sel;
  logic [RES_W-1:0]          alu_result;
  // Captured result handshake
  logic [RES_W-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_data, out_valid
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end and result back-end for a small combinational ALU.
// Commands are buffered in a 2-entry FIFO, issued to the ALU from registers,
// captured after a one-cycle settle window and presented with valid/ready.
module alu_cmd_sequencer #(
  parameter int DATA_W     = 3,
  parameter int SEL_W      = 2,
  parameter int RES_W      = 6,
  parameter int FIFO_DEPTH = 2   // only 2 is supported (1-bit pointers)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic                 busy_o,
  output logic [7:0]           op_count_o,
  output logic                 op_wrap_o
);

  localparam int CMD_W = 2 * DATA_W + SEL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [CMD_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fifo_cnt_q;
  logic [1:0]        fifo_cnt_d;

  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [RES_W-1:0]  out_data_q;
  logic              out_valid_q;
  logic [7:0]        op_count_q;
  logic              op_wrap_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              out_hs;
  logic [CMD_W-1:0]  head;

  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign fifo_full  = (fifo_cnt_q == 2'(FIFO_DEPTH));
  // in_ready depends only on the registered count, never on a same-cycle pop
  assign push       = bus.in_valid && !fifo_full;
  assign out_hs     = (state_q == ST_HOLD) && bus.out_ready;
  // The head is consumed when idle, or on the output handshake for back-to-back issue
  assign pop        = !fifo_empty && ((state_q == ST_IDLE) || out_hs);
  assign head       = fifo_mem_q[rd_ptr_q];

  assign bus.in_ready  = !fifo_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
  assign op_count_o    = op_count_q;
  assign op_wrap_o     = op_wrap_q;

  // Per-entry FIFO storage: an entry is written when the write pointer selects it
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_mem_q[gi] <= '0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          fifo_mem_q[gi] <= bus.in_data;
        end
      end
    end
  endgenerate

  // Next FIFO occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Sequencer next state: ISSUE is a fixed one-cycle ALU settle window
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD:  if (bus.out_ready) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operand registers change only when a command is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (pop) begin
      alu_a_q   <= head[DATA_W-1:0];
      alu_b_q   <= head[2*DATA_W-1:DATA_W];
      alu_sel_q <= head[CMD_W-1:2*DATA_W];
    end
  end

  // Result register: capture at the end of ISSUE, release on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == ST_ISSUE) begin
      out_data_q  <= bus.alu_result;
      out_valid_q <= 1'b1;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Completed-operation counter with a sticky wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 8'd0;
      op_wrap_q  <= 1'b0;
    end else if (out_hs) begin
      op_count_q <= op_count_q + 8'd1;
      if (op_count_q == 8'hFF) op_wrap_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives
// alu_result, a queue scoreboard predicts results in push order.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] op_count;
  logic       op_wrap;

  int         n_cmp;
  int         n_err;
  logic [5:0] sb_q[$];
  logic [7:0] exp_ops;

  alu_cmd_sequencer_if #(.DATA_W(3), .SEL_W(2), .RES_W(6)) bus ();

  alu_cmd_sequencer #(
    .DATA_W(3), .SEL_W(2), .RES_W(6), .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .op_count_o (op_count),
    .op_wrap_o  (op_wrap)
  );

  // Behavioural ALU: 0=add, 1=sub, 2=xor, 3=mul (6-bit result)
  function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b,
                                           input logic [1:0] s);
    logic [5:0] r;
    case (s)
      2'd0:    r = 6'(a) + 6'(b);
      2'd1:    r = 6'(a) - 6'(b);
      2'd2:    r = {3'b000, a ^ b};
      default: r = 6'(a) * 6'(b);
    endcase
    return r;
  endfunction

  function automatic logic [5:0] exp_of(input logic [7:0] cmd);
    return alu_model(cmd[2:0], cmd[5:3], cmd[7:6]);
  endfunction

  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor at the falling edge: handshakes seen here complete at the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(exp_of(bus.in_data));
        $display("push cmd=0x%02h exp=%0d", bus.in_data, exp_of(bus.in_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_ops = exp_ops + 8'd1;
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(1), 32'(0));
        end else begin
          logic [5:0] e;
          e = sb_q.pop_front();
          $display("result data=%0d exp=%0d", bus.out_data, e);
          check_eq("out_data", 32'(bus.out_data), 32'(e));
        end
      end
    end
  end

  // Present one command and hold it until accepted (bounded)
  task automatic push_cmd(input logic [7:0] cmd);
    bit done;
    done = 1'b0;
    bus.in_data  = cmd;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check_eq("push_timeout", 32'(0), 32'(1));
  endtask

  // Wait until every predicted result has been consumed and the block is idle
  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) check_eq("drain_timeout", 32'(0), 32'(1));
  endtask

  logic [7:0] cmds [3];
  logic [5:0] held;
  int         gap;
  int         need;

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_ops = 8'd0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_op_count", 32'(op_count), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_alu_a", 32'(bus.alu_a), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_eq("rel_in_ready", 32'(bus.in_ready), 32'(1));

    // Single command latency: sel=1, B=3, A=5 -> 5-3=2
    push_cmd(8'b01_011_101);
    check_eq("lat_e0_alu_a", 32'(bus.alu_a), 32'(0));
    @(posedge clk); #1;
    check_eq("lat_alu_a", 32'(bus.alu_a), 32'(5));
    check_eq("lat_alu_b", 32'(bus.alu_b), 32'(3));
    check_eq("lat_alu_sel", 32'(bus.alu_sel), 32'(1));
    check_eq("lat_e1_out_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk); #1;
    check_eq("lat_out_valid", 32'(bus.out_valid), 32'(1));
    check_eq("lat_out_data", 32'(bus.out_data), 32'(2));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("single_op_count", 32'(op_count), 32'(1));
    check_eq("single_busy", 32'(busy), 32'(0));
    check_eq("single_out_valid", 32'(bus.out_valid), 32'(0));
    bus.out_ready = 1'b0;

    // Backpressure: first command reaches HOLD, next two fill the FIFO
    for (int i = 0; i < 3; i++) cmds[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) push_cmd(cmds[i]);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'(0));
    check_eq("full_out_valid", 32'(bus.out_valid), 32'(1));
    held = bus.out_data;
    check_eq("full_head_data", 32'(held), 32'(exp_of(cmds[0])));
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("full_reject", 32'(bus.in_ready), 32'(0));
    end
    bus.in_valid = 1'b0;
    check_eq("hold_stable", 32'(bus.out_data), 32'(held));

    // Release: back-to-back results, alu_* reloaded on the handshake edge
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      while (!bus.out_valid && gap < 10) begin
        @(posedge clk); #1;
        gap++;
      end
      if (k > 0) check_eq("b2b_gap", 32'(gap), 32'(1));
      check_eq("b2b_data", 32'(bus.out_data), 32'(exp_of(cmds[k])));
      @(posedge clk); #1;
      check_eq("b2b_pulse", 32'(bus.out_valid), 32'(0));
      if (k < 2) begin
        check_eq("b2b_reload_a", 32'(bus.alu_a), 32'(cmds[k+1][2:0]));
        check_eq("b2b_reload_b", 32'(bus.alu_b), 32'(cmds[k+1][5:3]));
        check_eq("b2b_reload_sel", 32'(bus.alu_sel), 32'(cmds[k+1][7:6]));
      end
    end
    check_eq("b2b_busy", 32'(busy), 32'(0));
    check_eq("b2b_op_count", 32'(op_count), 32'(4));
    bus.out_ready = 1'b0;

    // Random stream with random backpressure: exercises push/pop in the same edge
    fork
      begin
        for (int i = 0; i < 10; i++) push_cmd(8'($urandom));
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check_eq("stream_sb_empty", 32'(sb_q.size()), 32'(0));
    check_eq("stream_op_count", 32'(op_count), 32'(exp_ops));

    // Same-cycle push into a one-entry FIFO while idle, continuous input
    for (int i = 0; i < 6; i++) push_cmd(8'($urandom));
    drain();
    check_eq("pp_op_count", 32'(op_count), 32'(exp_ops));

    // Counter wrap
    need = 255 - int'(exp_ops);
    for (int i = 0; i < need; i++) push_cmd(8'($urandom));
    drain();
    check_eq("pre_wrap_count", 32'(op_count), 32'(255));
    check_eq("pre_wrap_flag", 32'(op_wrap), 32'(0));
    push_cmd(8'($urandom));
    drain();
    check_eq("wrap_count", 32'(op_count), 32'(0));
    check_eq("wrap_flag", 32'(op_wrap), 32'(1));
    push_cmd(8'($urandom));
    drain();
    check_eq("post_wrap_count", 32'(op_count), 32'(1));
    check_eq("post_wrap_flag", 32'(op_wrap), 32'(1));

    // Asynchronous reset in the middle of HOLD
    bus.out_ready = 1'b0;
    push_cmd(8'b11_111_111);
    gap = 0;
    while (!bus.out_valid && gap < 10) begin
      @(posedge clk); #1;
      gap++;
    end
    check_eq("mid_hold_valid", 32'(bus.out_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("async_op_count", 32'(op_count), 32'(0));
    check_eq("async_op_wrap", 32'(op_wrap), 32'(0));
    check_eq("async_alu_a", 32'(bus.alu_a), 32'(0));
    check_eq("async_alu_sel", 32'(bus.alu_sel), 32'(0));
    check_eq("async_out_data", 32'(bus.out_data), 32'(0));
    check_eq("async_busy", 32'(busy), 32'(0));
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rerel_in_ready", 32'(bus.in_ready), 32'(1));
    check_eq("rerel_out_valid", 32'(bus.out_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
